// File: rtl/if_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_id_hazard_ctrl
// Brief    : Front-end hazard/stall controller: PC enable, IF/ID hold/NOP,
//            ID/EX bubble, back-end freeze, squash of wrong-path fetches.
// Revision : 1.0
// ============================================================================
module if_id_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_busywait,
    input  logic              dmem_busywait,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    output logic              pc_write_en,
    output logic              if_id_busywait,
    output logic              if_id_nop_sel,
    output logic              id_ex_nop_sel,
    output logic              ex_mem_busywait,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_pc_we;
    logic w_ifid_hold;
    logic w_ifid_nop;
    logic w_idex_nop;
    logic w_exmem_hold;
    logic w_flush_inc;

    assign w_lu = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_pc_we      = 1'b0;
        w_ifid_hold  = 1'b0;
        w_ifid_nop   = 1'b0;
        w_idex_nop   = 1'b0;
        w_exmem_hold = 1'b0;
        w_flush_inc  = 1'b0;
        w_state_nxt  = r_state;

        if (dmem_busywait) begin
            // EX is frozen too, so a pending redirect re-presents next cycle
            w_ifid_hold  = 1'b1;
            w_exmem_hold = 1'b1;
        end else if (ex_redirect) begin
            w_pc_we     = 1'b1;
            w_ifid_nop  = 1'b1;
            w_idex_nop  = 1'b1;
            w_flush_inc = 1'b1;
            w_state_nxt = imem_busywait ? ST_SQUASH : ST_RUN;
        end else if (r_state == ST_SQUASH) begin
            w_idex_nop = 1'b1;
            if (imem_busywait) begin
                w_ifid_hold = 1'b1;
            end else begin
                w_ifid_nop  = 1'b1;
                w_state_nxt = ST_RUN;
            end
        end else if (w_lu || imem_busywait) begin
            w_ifid_hold = 1'b1;
            w_idex_nop  = 1'b1;
        end else begin
            w_pc_we = 1'b1;
        end
    end

    // Reset overrides the decision so the pipeline is flushed while held
    assign pc_write_en     = reset & w_pc_we;
    assign if_id_busywait  = reset & w_ifid_hold;
    assign if_id_nop_sel   = ~reset | w_ifid_nop;
    assign id_ex_nop_sel   = ~reset | w_idex_nop;
    assign ex_mem_busywait = reset & w_exmem_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_pc_we && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_hazard_ctrl
// Brief    : Scoreboard bench for if_id_hazard_ctrl (32-bit and 4-bit counters).
// Revision : 1.0
// ============================================================================
module tb_if_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       imem_busywait = 1'b0;
    logic       dmem_busywait = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_mem_read = 1'b0;
    logic       ex_redirect = 1'b0;

    logic        pc_write_en, if_id_busywait, if_id_nop_sel, id_ex_nop_sel, ex_mem_busywait;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_write_en4, if_id_busywait4, if_id_nop_sel4, id_ex_nop_sel4, ex_mem_busywait4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    if_id_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .pc_write_en(pc_write_en), .if_id_busywait(if_id_busywait), .if_id_nop_sel(if_id_nop_sel),
        .id_ex_nop_sel(id_ex_nop_sel), .ex_mem_busywait(ex_mem_busywait),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .pc_write_en(pc_write_en4), .if_id_busywait(if_id_busywait4), .if_id_nop_sel(if_id_nop_sel4),
        .id_ex_nop_sel(id_ex_nop_sel4), .ex_mem_busywait(ex_mem_busywait4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        string  tag;
        bit     pc, ifb, ifn, idn, exb;
        longint stall, flush, stall4, flush4;
    } exp_t;

    exp_t   sb_q[$];
    event   ev_sample;
    int     checks = 0;
    int     failures = 0;

    // Reference model: a single "discarding a wrong-path fetch" flag and counters
    bit     m_squash = 1'b0;
    longint m_stall = 0, m_flush = 0, m_stall4 = 0, m_flush4 = 0;

    function automatic longint sat_inc(longint v, longint lim);
        return (v < lim) ? v + 1 : lim;
    endfunction

    task automatic chk(input string tag, input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d t=%0t", tag, name, act, req, $time);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit dmem, input bit imem,
                        input bit redir, input bit mr, input bit u1, input bit u2,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        exp_t e;
        bit   hazard;
        @(negedge clk);
        reset = rst; dmem_busywait = dmem; imem_busywait = imem; ex_redirect = redir;
        ex_mem_read = mr; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rs1 = r1; id_rs2 = r2; ex_rd = rd;

        hazard = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        if (!rst) begin
            m_squash = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        end
        e.tag = tag;
        {e.pc, e.ifb, e.ifn, e.idn, e.exb} = 5'b00000;
        if (!rst)                  {e.ifn, e.idn} = 2'b11;
        else if (dmem)             {e.ifb, e.exb} = 2'b11;
        else if (redir)            {e.pc, e.ifn, e.idn} = 3'b111;
        else if (m_squash && imem) {e.ifb, e.idn} = 2'b11;
        else if (m_squash)         {e.ifn, e.idn} = 2'b11;
        else if (hazard || imem)   {e.ifb, e.idn} = 2'b11;
        else                       e.pc = 1'b1;
        e.stall = m_stall; e.flush = m_flush; e.stall4 = m_stall4; e.flush4 = m_flush4;
        sb_q.push_back(e);
        -> ev_sample;

        // Effect of the coming rising edge
        if (rst) begin
            if (!e.pc) begin
                m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
                m_stall4 = sat_inc(m_stall4, 15);
            end
            if (!dmem && redir) begin
                m_flush  = sat_inc(m_flush, 64'hFFFF_FFFF);
                m_flush4 = sat_inc(m_flush4, 15);
                m_squash = imem;
            end else if (!dmem && m_squash && !imem) begin
                m_squash = 0;
            end
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_sample);
            #1;
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = sb_q.pop_front();
                chk(e.tag, "pc_write_en",     pc_write_en,     e.pc);
                chk(e.tag, "if_id_busywait",  if_id_busywait,  e.ifb);
                chk(e.tag, "if_id_nop_sel",   if_id_nop_sel,   e.ifn);
                chk(e.tag, "id_ex_nop_sel",   id_ex_nop_sel,   e.idn);
                chk(e.tag, "ex_mem_busywait", ex_mem_busywait, e.exb);
                chk(e.tag, "stall_cnt",       stall_cnt,       e.stall);
                chk(e.tag, "flush_cnt",       flush_cnt,       e.flush);
                chk(e.tag, "stall_cnt4",      stall_cnt4,      e.stall4);
                chk(e.tag, "flush_cnt4",      flush_cnt4,      e.flush4);
                chk(e.tag, "pc_write_en4",    pc_write_en4,    e.pc);
                chk(e.tag, "id_ex_nop_sel4",  id_ex_nop_sel4,  e.idn);
            end
        end
    end

    initial begin : stimulus
        // Reset held with random inputs
        for (int i = 0; i < 3; i++)
            step("reset", 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        idle("release", 2);

        // Load-use on rs2, then the load moves on; ex_rd=0 never stalls
        step("lu",      1, 0, 0, 0, 1, 0, 1, 5'd1, 5'd5, 5'd5);
        step("lu_done", 1, 0, 0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd7);
        step("lu_x0",   1, 0, 0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0);

        // Redirect beats a simultaneous load-use
        step("redir_lu", 1, 0, 0, 1, 1, 1, 0, 5'd3, 5'd0, 5'd3);
        idle("after_redir", 1);

        // Redirect during a fetch miss: squash for two more cycles
        step("redir_miss", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("squash1",    1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("squash2",    1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("squash_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("run", 1);

        // dmem freeze hides redirect and imem miss, redirect taken after
        for (int i = 0; i < 4; i++) step("freeze", 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("post_freeze", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle("run2", 1);

        // Saturate the narrow stall counter
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle("sat_end", 1);

        // Reset in the middle of a squash leaves no residue
        step("sq_enter", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("sq_hold",  1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("sq_reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("sq_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with small register indices to provoke matches
        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 40), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));

        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
